// File: rtl/lab3_cache_mem_arbiter.sv
// Burst arbiter sharing one memory port between two cache controllers.
// Define LAB3_CACHE_MEMARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module lab3_cache_mem_arbiter #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [76:0] req0_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [76:0] req1_msg,

    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [46:0] resp0_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [46:0] resp1_msg,

    output logic        mem_req_val,
    input  logic        mem_req_rdy,
    output logic [76:0] mem_req_msg,
    input  logic        mem_resp_val,
    output logic        mem_resp_rdy,
    input  logic [46:0] mem_resp_msg,

    output logic        owner,
    output logic        busy
);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             owner_n;
    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] sent_n;
    logic [CNT_W-1:0] recv_cnt;
    logic [CNT_W-1:0] recv_n;
    logic             winner;
    logic             req_fire;
    logic             resp_fire;
`ifdef LAB3_CACHE_MEMARB_RR_EN
    logic             prio;
    logic             prio_n;
`endif

    assign busy = (state != IDLE);

    // Arbitration winner for the IDLE cycle
    always_comb begin
`ifdef LAB3_CACHE_MEMARB_RR_EN
        winner = (req0_val && req1_val) ? prio : req1_val;
`else
        winner = ~req0_val;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            sent_cnt <= '0;
            recv_cnt <= '0;
`ifdef LAB3_CACHE_MEMARB_RR_EN
            prio     <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            sent_cnt <= sent_n;
            recv_cnt <= recv_n;
`ifdef LAB3_CACHE_MEMARB_RR_EN
            prio     <= prio_n;
`endif
        end
    end

    // Next state, counters and the zero-latency passthrough paths
    always_comb begin
        state_n      = state;
        owner_n      = owner;
`ifdef LAB3_CACHE_MEMARB_RR_EN
        prio_n       = prio;
`endif
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        resp0_msg    = '0;
        resp1_msg    = '0;
        mem_req_val  = 1'b0;
        mem_req_msg  = '0;
        mem_resp_rdy = 1'b0;
        req_fire     = 1'b0;
        resp_fire    = 1'b0;

        if (state == SEND) begin
            mem_req_val = owner ? req1_val : req0_val;
            mem_req_msg = owner ? req1_msg : req0_msg;
            req0_rdy    = ~owner & mem_req_rdy;
            req1_rdy    = owner & mem_req_rdy;
            req_fire    = mem_req_val & mem_req_rdy;
        end

        if (state != IDLE) begin
            resp0_val    = ~owner & mem_resp_val;
            resp1_val    = owner & mem_resp_val;
            resp0_msg    = owner ? '0 : mem_resp_msg;
            resp1_msg    = owner ? mem_resp_msg : '0;
            mem_resp_rdy = owner ? resp1_rdy : resp0_rdy;
            resp_fire    = mem_resp_val & mem_resp_rdy;
        end

        sent_n = sent_cnt + CNT_W'(req_fire);
        recv_n = recv_cnt + CNT_W'(resp_fire);

        case (state)
            IDLE: begin
                if (req0_val || req1_val) begin
                    state_n = SEND;
                    owner_n = winner;
                    sent_n  = '0;
                    recv_n  = '0;
                end
            end
            SEND, DRAIN: begin
                // Last response may land while still in SEND with a combinational memory
                if (recv_n == CNT_LAST) begin
                    state_n = IDLE;
`ifdef LAB3_CACHE_MEMARB_RR_EN
                    prio_n  = ~owner;
`endif
                end else if (sent_n == CNT_LAST) begin
                    state_n = DRAIN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Randomized bench for lab3_cache_mem_arbiter: two cache sources, a word memory and a burst-level reference model.
module tb_lab3_cache_mem_arbiter;
    localparam int unsigned BL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [76:0] req0_msg, req1_msg, mem_req_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [46:0] resp0_msg, resp1_msg, mem_resp_msg;
    logic        mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic        owner, busy;

    always #5 clk = ~clk;

    lab3_cache_mem_arbiter #(.BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .owner(owner), .busy(busy)
    );

    typedef struct {
        logic [46:0] msg;
        int          ready;
    } mem_ent_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [76:0] q0[$];
    logic [76:0] q1[$];
    logic [46:0] exp0[$];
    logic [46:0] exp1[$];
    mem_ent_t    memq[$];
    logic [31:0] mem_a [256];
    logic [31:0] mem_r [256];
    logic [31:0] rd1_log[$];
    int          g_log[$];
    int          gap_log[$];

    int unsigned lat, req_rdy_pct, resp_rdy_pct, drop_pct;
    bit          toggle_rdy;
    int          resp_hold;

    bit          m_busy, m_owner;
    int unsigned m_sent, m_recv;
`ifdef LAB3_CACHE_MEMARB_RR_EN
    bit          m_prio;
`endif
    bit          prev_busy;
    int          idle_run, busy_cycles, req_fires0, resp_fires0;

    function automatic logic [76:0] mk_req(logic wr, logic [7:0] op, logic [31:0] addr, logic [31:0] data);
        return {2'b00, wr, op, addr, 2'b00, data};
    endfunction

    // Memory response: type/opaque/len echoed, read data or zero for a write ack
    function automatic logic [46:0] mk_resp(logic [76:0] r, logic [31:0] rdata);
        return {r[76:74], r[73:66], 2'b00, r[33:32], (r[76:74] == 3'd1) ? 32'h0 : rdata};
    endfunction

    task automatic clear_tb_state();
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); memq.delete();
        m_busy = 1'b0; m_owner = 1'b0; m_sent = 0; m_recv = 0;
`ifdef LAB3_CACHE_MEMARB_RR_EN
        m_prio = 1'b0;
`endif
        prev_busy = 1'b0; idle_run = 0;
    endtask

    task automatic clear_logs();
        g_log.delete(); gap_log.delete(); rd1_log.delete();
        busy_cycles = 0; req_fires0 = 0; resp_fires0 = 0;
    endtask

    task automatic zero_inputs();
        req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
        resp0_rdy = 0; resp1_rdy = 0; mem_req_rdy = 0; mem_resp_val = 0; mem_resp_msg = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        zero_inputs();
        reset = 1'b0;
        clear_tb_state();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic add_burst(int port, logic wr, logic [31:0] base, logic [31:0] data, logic [31:0] dstep);
        for (int i = 0; i < int'(BL); i++) begin
            if (port == 0) q0.push_back(mk_req(wr, 8'(i), base + 32'(4 * i), data + dstep * 32'(i)));
            else           q1.push_back(mk_req(wr, 8'(i), base + 32'(4 * i), data + dstep * 32'(i)));
        end
    endtask

    task automatic add_rand_burst(int port);
        logic [76:0] r;
        for (int i = 0; i < int'(BL); i++) begin
            r = mk_req(1'($urandom_range(1)), 8'($urandom), 32'h1000 + 32'(4 * $urandom_range(255)), $urandom);
            if (port == 0) q0.push_back(r);
            else           q1.push_back(r);
        end
    endtask

    // Per-cycle monitor: compares handshake outputs with the burst-level model and scores messages
    task automatic check_cycle();
        logic [7:0]  got, exp;
        logic        snd, own_val, own_rrdy, w;
        logic [76:0] r;
        logic [46:0] e;
        logic [7:0]  idx;
        got = {busy, m_busy ? owner : 1'b0, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_req_val, mem_resp_rdy};
        exp = '0;
        snd = (m_sent < BL);
        own_val  = m_owner ? req1_val : req0_val;
        own_rrdy = m_owner ? resp1_rdy : resp0_rdy;
        if (m_busy) begin
            exp[7] = 1'b1;
            exp[6] = m_owner;
            exp[5] = !m_owner && snd && mem_req_rdy;
            exp[4] = m_owner && snd && mem_req_rdy;
            exp[3] = !m_owner && mem_resp_val;
            exp[2] = m_owner && mem_resp_val;
            exp[1] = snd && own_val;
            exp[0] = own_rrdy;
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL handshake cyc=%0d got=%b expected=%b", cyc, got, exp);
        end

        if (req0_val && req0_rdy) begin
            r = q0.pop_front();
            vectors++;
            if (mem_req_msg !== r) begin
                miscompares++;
                $display("FAIL fwd_req0 cyc=%0d got=%h expected=%h", cyc, mem_req_msg, r);
            end
            idx = r[43:36];
            if (r[76:74] == 3'd1) mem_r[idx] = r[31:0];
            exp0.push_back(mk_resp(r, mem_r[idx]));
            req_fires0++;
        end
        if (req1_val && req1_rdy) begin
            r = q1.pop_front();
            vectors++;
            if (mem_req_msg !== r) begin
                miscompares++;
                $display("FAIL fwd_req1 cyc=%0d got=%h expected=%h", cyc, mem_req_msg, r);
            end
            idx = r[43:36];
            if (r[76:74] == 3'd1) mem_r[idx] = r[31:0];
            exp1.push_back(mk_resp(r, mem_r[idx]));
        end
        if (resp0_val && resp0_rdy) begin
            vectors++;
            resp_fires0++;
            if (exp0.size() == 0) begin
                miscompares++;
                $display("FAIL resp0_extra cyc=%0d got=%h expected=none", cyc, resp0_msg);
            end else begin
                e = exp0.pop_front();
                if (resp0_msg !== e) begin
                    miscompares++;
                    $display("FAIL resp0_msg cyc=%0d got=%h expected=%h", cyc, resp0_msg, e);
                end
            end
        end
        if (resp1_val && resp1_rdy) begin
            vectors++;
            rd1_log.push_back(resp1_msg[31:0]);
            if (exp1.size() == 0) begin
                miscompares++;
                $display("FAIL resp1_extra cyc=%0d got=%h expected=none", cyc, resp1_msg);
            end else begin
                e = exp1.pop_front();
                if (resp1_msg !== e) begin
                    miscompares++;
                    $display("FAIL resp1_msg cyc=%0d got=%h expected=%h", cyc, resp1_msg, e);
                end
            end
        end
        if (mem_resp_val && mem_resp_rdy) void'(memq.pop_front());

        // Burst-level reference: grant, count requests and responses, release
        if (!m_busy) begin
            if (req0_val || req1_val) begin
`ifdef LAB3_CACHE_MEMARB_RR_EN
                w = (req0_val && req1_val) ? m_prio : req1_val;
`else
                w = !req0_val;
`endif
                m_busy = 1'b1; m_owner = w; m_sent = 0; m_recv = 0;
            end
        end else begin
            if (snd && own_val && mem_req_rdy) m_sent++;
            if (mem_resp_val && own_rrdy) m_recv++;
            if (m_recv == BL) begin
                m_busy = 1'b0;
`ifdef LAB3_CACHE_MEMARB_RR_EN
                m_prio = !m_owner;
`endif
            end
        end

        if (busy && !prev_busy) begin
            g_log.push_back(int'(owner));
            gap_log.push_back(idle_run);
        end
        if (busy) begin busy_cycles++; idle_run = 0; end
        else idle_run++;
        prev_busy = busy;
    endtask

    task automatic step();
        logic [76:0] r;
        mem_ent_t    ent;
        logic [7:0]  idx;
        @(posedge clk);
        cyc++;
        #1;
        req0_val = (q0.size() != 0) && ($urandom_range(99) >= drop_pct);
        req0_msg = (q0.size() != 0) ? q0[0] : '0;
        req1_val = (q1.size() != 0) && ($urandom_range(99) >= drop_pct);
        req1_msg = (q1.size() != 0) ? q1[0] : '0;
        mem_req_rdy = toggle_rdy ? ~cyc[0] : ($urandom_range(99) < req_rdy_pct);
        resp0_rdy = (resp_hold > 0) ? 1'b0 : ($urandom_range(99) < resp_rdy_pct);
        if (resp_hold > 0) resp_hold--;
        resp1_rdy = ($urandom_range(99) < resp_rdy_pct);
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
        #1;
        if (mem_req_val && mem_req_rdy) begin
            r = mem_req_msg;
            idx = r[43:36];
            if (r[76:74] == 3'd1) mem_a[idx] = r[31:0];
            ent.msg = mk_resp(r, mem_a[idx]);
            ent.ready = cyc + int'(lat);
            memq.push_back(ent);
        end
        if (memq.size() != 0 && memq[0].ready <= cyc) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = memq[0].msg;
        end
        #1;
        check_cycle();
    endtask

    task automatic run_until_idle(int max_cycles);
        int n = 0;
        do begin
            step();
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || m_busy || memq.size() != 0 ||
                    exp0.size() != 0 || exp1.size() != 0) && n < max_cycles);
        if (q0.size() != 0 || q1.size() != 0 || m_busy || exp0.size() != 0 || exp1.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout got=busy_after_%0d_cycles expected=idle", n);
        end
    endtask

    task automatic wait_model_busy();
        int n = 0;
        while (!m_busy && n < 20) begin step(); n++; end
        vectors++;
        if (!m_busy) begin
            miscompares++;
            $display("FAIL grant_wait got=idle expected=busy");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_val = 1; req1_val = 1; req0_msg = {77{1'b1}}; req1_msg = {77{1'b1}};
        resp0_rdy = 1; resp1_rdy = 1; mem_req_rdy = 1; mem_resp_val = 1; mem_resp_msg = {47{1'b1}};
        clear_tb_state();
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({busy, owner, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_req_val, mem_resp_rdy} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b expected=00000000",
                     {busy, owner, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_req_val, mem_resp_rdy});
        end
        vectors++;
        if ({mem_req_msg, resp0_msg, resp1_msg} !== '0) begin
            miscompares++;
            $display("FAIL reset_msg got=%h expected=0", {mem_req_msg, resp0_msg, resp1_msg});
        end
        zero_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_burst();
        lat = 1; req_rdy_pct = 100; resp_rdy_pct = 100; drop_pct = 0; toggle_rdy = 0; resp_hold = 0;
        clear_logs();
        add_burst(0, 1'b0, 32'h1000, 32'h0, 32'h0);
        run_until_idle(50);
        vectors++;
        if (busy_cycles != 5) begin
            miscompares++;
            $display("FAIL single_busy_cycles got=%0d expected=5", busy_cycles);
        end
        vectors++;
        if (g_log.size() != 1 || g_log[0] != 0) begin
            miscompares++;
            $display("FAIL single_owner got=%0d grants expected=1 grant to port 0", g_log.size());
        end
        vectors++;
        if (resp_fires0 != 4) begin
            miscompares++;
            $display("FAIL single_resp_count got=%0d expected=4", resp_fires0);
        end
    endtask

    task automatic test_simultaneous();
        int exp_order[4];
`ifdef LAB3_CACHE_MEMARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        apply_reset();
        lat = $urandom_range(2); req_rdy_pct = 100; resp_rdy_pct = 100; drop_pct = 0; toggle_rdy = 0; resp_hold = 0;
        clear_logs();
        add_burst(0, 1'b0, 32'h1000, 32'h0, 32'h0);
        add_burst(0, 1'b0, 32'h1010, 32'h0, 32'h0);
        add_burst(1, 1'b0, 32'h1020, 32'h0, 32'h0);
        add_burst(1, 1'b0, 32'h1030, 32'h0, 32'h0);
        run_until_idle(200);
        vectors++;
        if (g_log.size() != 4) begin
            miscompares++;
            $display("FAIL sim_grant_count got=%0d expected=4", g_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (g_log[i] != exp_order[i]) begin
                    miscompares++;
                    $display("FAIL sim_grant_order idx=%0d got=%0d expected=%0d", i, g_log[i], exp_order[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (gap_log[i] != 1) begin
                    miscompares++;
                    $display("FAIL sim_idle_gap idx=%0d got=%0d expected=1", i, gap_log[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        lat = 1; req_rdy_pct = 100; resp_rdy_pct = 100; drop_pct = 0; toggle_rdy = 1; resp_hold = 5;
        clear_logs();
        add_burst(0, 1'b0, 32'h1040, 32'h0, 32'h0);
        run_until_idle(100);
        toggle_rdy = 0;
        vectors++;
        if (req_fires0 != 4 || resp_fires0 != 4) begin
            miscompares++;
            $display("FAIL bp_counts got=%0d/%0d expected=4/4", req_fires0, resp_fires0);
        end
    endtask

    task automatic test_isolation();
        lat = 2; req_rdy_pct = 70; resp_rdy_pct = 70; drop_pct = 10; toggle_rdy = 0; resp_hold = 0;
        clear_logs();
        add_burst(0, 1'b0, 32'h1080, 32'h0, 32'h0);
        wait_model_busy();
        add_burst(1, 1'b0, 32'h1090, 32'h0, 32'h0);
        run_until_idle(200);
        vectors++;
        if (g_log.size() != 2 || g_log[0] != 0 || g_log[1] != 1) begin
            miscompares++;
            $display("FAIL iso_grants got=%0d grants expected=port 0 then port 1", g_log.size());
        end
    endtask

    task automatic test_write_read();
        lat = 1; req_rdy_pct = 80; resp_rdy_pct = 80; drop_pct = 0; toggle_rdy = 0; resp_hold = 0;
        clear_logs();
        add_burst(0, 1'b1, 32'h1100, 32'hdeadbeef, 32'h01010101);
        wait_model_busy();
        add_burst(1, 1'b0, 32'h1100, 32'h0, 32'h0);
        run_until_idle(200);
        vectors++;
        if (resp_fires0 != 4) begin
            miscompares++;
            $display("FAIL wr_acks got=%0d expected=4", resp_fires0);
        end
        vectors++;
        if (rd1_log.size() != 4) begin
            miscompares++;
            $display("FAIL wr_readback_count got=%0d expected=4", rd1_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rd1_log[i] !== 32'hdeadbeef + 32'h01010101 * 32'(i)) begin
                    miscompares++;
                    $display("FAIL wr_readback idx=%0d got=%h expected=%h", i, rd1_log[i],
                             32'hdeadbeef + 32'h01010101 * 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        apply_reset();
        lat = 2; req_rdy_pct = 100; resp_rdy_pct = 100; drop_pct = 0; toggle_rdy = 0; resp_hold = 0;
        clear_logs();
        add_burst(0, 1'b0, 32'h1200, 32'h0, 32'h0);
        while (req_fires0 < 2 && n < 20) begin step(); n++; end
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({busy, owner, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_req_val, mem_resp_rdy} !== 8'h00 ||
            {mem_req_msg, resp0_msg, resp1_msg} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got=%b expected=all zero",
                     {busy, owner, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_req_val, mem_resp_rdy});
        end
        zero_inputs();
        clear_tb_state();
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        add_burst(0, 1'b0, 32'h1200, 32'h0, 32'h0);
        add_burst(1, 1'b0, 32'h1210, 32'h0, 32'h0);
        run_until_idle(200);
        vectors++;
        if (g_log.size() != 2 || g_log[0] != 0 || g_log[1] != 1) begin
            miscompares++;
            $display("FAIL post_reset_grants got=%0d grants expected=port 0 then port 1", g_log.size());
        end
    endtask

    task automatic test_random();
        int n0, n1;
        for (int it = 0; it < 12; it++) begin
            lat = $urandom_range(2);
            req_rdy_pct = $urandom_range(100, 30);
            resp_rdy_pct = $urandom_range(100, 30);
            drop_pct = $urandom_range(30);
            toggle_rdy = 0; resp_hold = 0;
            n0 = $urandom_range(2);
            n1 = $urandom_range(2);
            if (n0 + n1 == 0) n0 = 1;
            for (int b = 0; b < n0; b++) add_rand_burst(0);
            for (int b = 0; b < n1; b++) add_rand_burst(1);
            run_until_idle(2000);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_r[i] = '0;
        end
        lat = 1; req_rdy_pct = 100; resp_rdy_pct = 100; drop_pct = 0; toggle_rdy = 0; resp_hold = 0;
        clear_logs();
        test_reset();
        test_single_burst();
        test_simultaneous();
        test_backpressure();
        test_isolation();
        test_write_read();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
